// File: rtl/cpu_ctrl_if.sv
// Handshake/bus bundle between the control unit and its datapath/host.
// The master side drives run/din; the slave (cpu_ctrl) returns the control strobes.
interface cpu_ctrl_if #(
    parameter int word = 16,
    parameter int NREG = 8
);
    logic            run;
    logic [word-1:0] din;
    logic            ir_in;
    logic [NREG-1:0] r_in;
    logic [NREG-1:0] r_out;
    logic            a_in;
    logic            g_in;
    logic            g_out;
    logic            din_out;
    logic [1:0]      alu_op;
    logic            done;
    logic [8:0]      ir_q;

    modport master (
        output run, din,
        input  ir_in, r_in, r_out, a_in, g_in, g_out, din_out, alu_op, done, ir_q
    );

    modport slave (
        input  run, din,
        output ir_in, r_in, r_out, a_in, g_in, g_out, din_out, alu_op, done, ir_q
    );
endinterface

// File: rtl/cpu_ctrl.sv
// Multi-cycle control unit: fetches a 9-bit instruction, then sequences T1..T3
// with control strobes decoded combinationally from step, IR and run.
module cpu_ctrl #(
    parameter int word = 16,
    parameter int NREG = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    cpu_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {T0 = 2'd0, T1 = 2'd1, T2 = 2'd2, T3 = 2'd3} step_t;

    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVI = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;

    step_t      r_step;
    logic [8:0] r_ir;

    logic [2:0]      w_op;
    logic [2:0]      w_x;
    logic [2:0]      w_y;
    logic            w_addsub;
    logic [NREG-1:0] w_x_hot;
    logic [NREG-1:0] w_y_hot;
    logic            w_unused_din;

    assign w_op     = r_ir[8:6];
    assign w_x      = r_ir[5:3];
    assign w_y      = r_ir[2:0];
    assign w_addsub = (w_op == OP_ADD) || (w_op == OP_SUB);
    assign w_x_hot  = NREG'(1) << w_x;
    assign w_y_hot  = NREG'(1) << w_y;
    assign w_unused_din = ^bus.din[word-1:9];

    assign bus.ir_q = r_ir;

    // Step/IR sequencing; only add/sub continue past T1, anything else returns to T0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_step <= T0;
            r_ir   <= '0;
        end else begin
            unique case (r_step)
                T0: begin
                    if (bus.run) begin
                        r_ir   <= bus.din[8:0];
                        r_step <= T1;
                    end
                end
                T1:      r_step <= w_addsub ? T2 : T0;
                T2:      r_step <= w_addsub ? T3 : T0;
                default: r_step <= T0;
            endcase
        end
    end

    // Gated by rst_n so that run=1 during reset cannot raise ir_in.
    always_comb begin
        bus.ir_in   = 1'b0;
        bus.r_in    = '0;
        bus.r_out   = '0;
        bus.a_in    = 1'b0;
        bus.g_in    = 1'b0;
        bus.g_out   = 1'b0;
        bus.din_out = 1'b0;
        bus.alu_op  = 2'b00;
        bus.done    = 1'b0;
        if (rst_n) begin
            unique case (r_step)
                T0: bus.ir_in = bus.run;
                T1: begin
                    if (w_op == OP_MV) begin
                        bus.r_out = w_y_hot;
                        bus.r_in  = w_x_hot;
                        bus.done  = 1'b1;
                    end else if (w_op == OP_MVI) begin
                        bus.din_out = 1'b1;
                        bus.r_in    = w_x_hot;
                        bus.done    = 1'b1;
                    end else if (w_addsub) begin
                        bus.r_out = w_x_hot;
                        bus.a_in  = 1'b1;
                    end else begin
                        bus.done = 1'b1;
                    end
                end
                T2: begin
                    if (w_addsub) begin
                        bus.r_out  = w_y_hot;
                        bus.g_in   = 1'b1;
                        bus.alu_op = (w_op == OP_ADD) ? 2'b01 : 2'b10;
                    end
                end
                default: begin
                    if (w_addsub) begin
                        bus.g_out = 1'b1;
                        bus.r_in  = w_x_hot;
                        bus.done  = 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cpu_ctrl.sv
// Randomized bench for cpu_ctrl; expected strobes come from a per-instruction
// micro-step list built from the opcode/field rules.
module tb_cpu_ctrl;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    logic [23:0] exp_q[$];

    cpu_ctrl_if #(.word(16), .NREG(8)) bus_if ();

    cpu_ctrl #(.word(16), .NREG(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed view: {ir_in, r_in[7:0], r_out[7:0], a_in, g_in, g_out, din_out, alu_op[1:0], done}
    function automatic logic [23:0] mk(input int ii, input int rin, input int rout, input int ai,
                                       input int gi, input int go, input int dn, input int alu,
                                       input int d);
        return {1'(ii), 8'(rin), 8'(rout), 1'(ai), 1'(gi), 1'(go), 1'(dn), 2'(alu), 1'(d)};
    endfunction

    function automatic logic [23:0] actual();
        return {bus_if.ir_in, bus_if.r_in, bus_if.r_out, bus_if.a_in, bus_if.g_in,
                bus_if.g_out, bus_if.din_out, bus_if.alu_op, bus_if.done};
    endfunction

    // Expected outputs for the cycles after the fetch cycle, one entry per clock.
    function automatic void model(input int ir);
        int op;
        int x;
        int y;
        op = ir / 64;
        x  = (ir / 8) % 8;
        y  = ir % 8;
        exp_q.delete();
        case (op)
            0: exp_q.push_back(mk(0, 1 << x, 1 << y, 0, 0, 0, 0, 0, 1));
            1: exp_q.push_back(mk(0, 1 << x, 0, 0, 0, 0, 1, 0, 1));
            2, 3: begin
                exp_q.push_back(mk(0, 0, 1 << x, 1, 0, 0, 0, 0, 0));
                exp_q.push_back(mk(0, 0, 1 << y, 0, 1, 0, 0, op - 1, 0));
                exp_q.push_back(mk(0, 1 << x, 0, 0, 0, 1, 0, 0, 1));
            end
            default: exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1));
        endcase
    endfunction

    // Fetch plus full execution of one instruction; run during T2 optionally forced low.
    task automatic do_instr(input logic [8:0] ir, input logic [15:0] imm, input bit drop_t2);
        logic [15:0] rnd;
        logic [23:0] a;
        model(int'(ir));
        rnd = 16'($urandom);
        bus_if.run = 1'b1;
        bus_if.din = {rnd[15:9], ir};
        @(negedge clk);
        a = actual();
        total++;
        if (a !== mk(1, 0, 0, 0, 0, 0, 0, 0, 0)) begin
            bad++;
            $display("FAIL fetch ir=%h got=%h want=%h", ir, a, mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
        end
        @(posedge clk);
        #1;
        total++;
        if (bus_if.ir_q !== ir) begin
            bad++;
            $display("FAIL ir_q got=%h want=%h", bus_if.ir_q, ir);
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            bus_if.run = (drop_t2 && i == 1) ? 1'b0 : 1'($urandom);
            bus_if.din = (ir[8:6] == 3'b001 && i == 0) ? imm : 16'($urandom);
            @(negedge clk);
            a = actual();
            total++;
            if (a !== exp_q[i]) begin
                bad++;
                $display("FAIL step%0d ir=%h got=%h want=%h", i + 1, ir, a, exp_q[i]);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus_if.run = 1'b1;
        bus_if.din = 16'h0081;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (actual() !== 24'h0 || bus_if.ir_q !== 9'h0) begin
                bad++;
                $display("FAIL reset_hold got=%h ir_q=%h want=0", actual(), bus_if.ir_q);
            end
        end
        @(posedge clk);
        #1;
        bus_if.run = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            total++;
            if (actual() !== 24'h0) begin
                bad++;
                $display("FAIL reset_idle got=%h want=0", actual());
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_mvi_mv();
        do_instr(9'h048, 16'h00A5, 1'b0);
        do_instr(9'h011, 16'h0000, 1'b0);
    endtask

    task automatic test_add();
        do_instr(9'h081, 16'h0000, 1'b0);
    endtask

    task automatic test_sub();
        do_instr(9'h0ED, 16'h0000, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 3; k++)
            do_instr({3'b010, 6'($urandom)}, 16'h0000, k == 2);
    endtask

    task automatic test_reset_mid();
        logic [23:0] a;
        bus_if.run = 1'b1;
        bus_if.din = 16'h0081;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        a = actual();
        total++;
        if (a !== 24'h0) begin
            bad++;
            $display("FAIL reset_async got=%h want=0", a);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            total++;
            if (bus_if.done !== 1'b0 || actual() !== 24'h0) begin
                bad++;
                $display("FAIL reset_nodone got=%h want=0", actual());
            end
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        do_instr(9'h0D3, 16'h0000, 1'b0);
        do_instr(9'h1C0, 16'h0000, 1'b0);
    endtask

    task automatic test_random();
        logic [8:0] ir;
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 2) == 0) begin
                bus_if.run = 1'b0;
                bus_if.din = 16'($urandom);
                @(negedge clk);
                total++;
                if (actual() !== 24'h0) begin
                    bad++;
                    $display("FAIL idle got=%h want=0", actual());
                end
                @(posedge clk);
                #1;
            end
            ir = 9'($urandom_range(0, 511));
            do_instr(ir, 16'($urandom), 1'($urandom));
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst_n = 1'b0;
        bus_if.run = 1'b0;
        bus_if.din = '0;
        test_reset();
        test_mvi_mv();
        test_add();
        test_sub();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
